mpu_burst_reader: RTL
=====================

// Module: mpu_burst_reader
// PURPOSE
//  Upstream sequencer for i2c_master: on each start pulse, fetches one accel/temp/gyro sample from the MPU9250.
//  Writes register pointer START_REG, then reads 14 bytes in one multibyte transfer; master handles dir change.
//  Assembles big-endian bytes into seven signed 16-bit words, updated atomically, with a one-cycle valid strobe.
//  Aborts cleanly on bus NACK (i2c_err) or on a stalled master (watchdog).
// PARAMETERS
//  DEV_ADDR      7'h68   7-bit I2C device address driven on i2c_addr
//  START_REG     8'h3B   first register of the burst (ACCEL_XOUT_H)
//  TIMEOUT       4096    max clk cycles between i2c_next pulses while busy; must be >0
// PORTS
//  clk             in   1   system clock
//  rst             in   1   synchronous active-high reset
//  start           in   1   1-cycle request to fetch one sample; ignored while busy=1
//  busy            out  1   high from accepted start until DONE/ABORT exit
//  sample_valid    out  1   1-cycle strobe: all seven word outputs updated this cycle
//  accel_x/y/z     out  16  signed, {byte0,byte1}/{byte2,byte3}/{byte4,byte5}
//  temp            out  16  signed, {byte6,byte7}
//  gyro_x/y/z      out  16  signed, {byte8,byte9}/{byte10,byte11}/{byte12,byte13}
//  fault           out  1   1-cycle strobe on abort
//  fault_code      out  2   held until next fault: 2'b01 NACK, 2'b10 timeout, 2'b00 none since reset
//  i2c_en          out  1   to master: request another byte
//  i2c_addr        out  7   to master: constant DEV_ADDR
//  i2c_write       out  1   to master: 1 = write byte, 0 = read byte
//  i2c_wdata       out  8   to master: START_REG during pointer write, 8'h00 otherwise
//  i2c_multibyte_n out  1   to master: held 0 (chain bytes in one transaction)
//  i2c_next        in   1   from master: byte-complete pulse; rdata valid, controls sampled same cycle
//  i2c_rdata       in   8   from master: read byte, valid only when i2c_next=1 on a read byte
//  i2c_act         in   1   from master: bus transaction in progress
//  i2c_err         in   1   from master: NACK / bus error pulse
// BEHAVIOUR
//  Master contract: at each i2c_next, the master samples i2c_en/write/wdata to decide the following byte.
//  i2c_en=0 at an i2c_next ends the transaction with STOP.
//  All outputs registered. Reset: busy=0, sample_valid=0, fault=0, fault_code=0, all words=0.
//   Reset also forces i2c_en=0, i2c_write=1, i2c_wdata=0, i2c_addr=DEV_ADDR, i2c_multibyte_n=0, byte_cnt=0, FSM=IDLE.
//  FSM states:
//   IDLE: start=1 -> PTR.
//    On the cycle after start: i2c_en=1, i2c_write=1, i2c_wdata=START_REG, busy=1.
//   PTR: i2c_next -> READ; i2c_write<=0, i2c_wdata<=0, byte_cnt<=0.
//   READ: each i2c_next captures i2c_rdata into shadow[byte_cnt], byte_cnt++.
//    i2c_en<=0 on the i2c_next capturing byte 12, so STOP follows byte 13.
//    i2c_next capturing byte 13 -> DONE.
//   DONE: copy shadow to the 7 word outputs, sample_valid=1 for 1 cycle.
//    Exit to IDLE once i2c_act=0; busy=0 on return to IDLE.
//   ABORT: i2c_en<=0, fault=1 for 1 cycle, fault_code set. Wait i2c_act=0 -> IDLE.
//    Word outputs unchanged; no sample_valid.
//  Abort causes:
//   i2c_err=1 in PTR/READ: code 01.
//   Watchdog: counter reset on every i2c_next and on entry to PTR; reaching TIMEOUT in PTR/READ: code 10.
//   i2c_err and timeout in the same cycle: code 01 wins.
//  Boundaries:
//   start during busy: dropped, not queued.
//   start in the same cycle DONE/ABORT returns to IDLE: ignored.
//   i2c_next and i2c_err in the same cycle: err wins, byte discarded.
//   i2c_next outside PTR/READ: ignored.
//   byte_cnt width 4; never exceeds 13.
//   Shadow regs are never visible on outputs, so no tearing after a partial read.
//   rst mid-transfer: i2c_en drops next cycle; master completes/aborts its own byte.
// TESTING
//  BFM replies bytes 01..0E; start -> first the pointer write.
//   Pointer write: i2c_addr=68, i2c_write=1, wdata=3B.
//   Then 14 reads; accel_x=0102, gyro_z=0D0E.
//   One sample_valid pulse; i2c_en low before byte 13's i2c_next.
//  Negative data: bytes FF,38 at index 0,1 -> accel_x=16'hFF38 (-200).
//   Back-to-back starts give two valid strobes.
//  i2c_err pulse at read byte 5 -> fault=1, fault_code=01, no sample_valid.
//   Word outputs keep the previous sample; busy drops after i2c_act=0.
//  BFM stops pulsing i2c_next after byte 3, TIMEOUT=64.
//   Expect fault 64 cycles after last next, code 10, i2c_en=0.
//  start asserted every cycle for 2 samples -> exactly 2 transfers, no extra pointer writes.
//  rst asserted at read byte 7 -> next cycle all outputs at reset values.
//   A fresh start afterwards completes normally.

Source files
------------

// File: rtl/mpu_burst_reader_if.sv
// ---------------------------------------------------------------------------
// mpu_burst_reader_if
//   Byte-level handshake between the MPU9250 burst sequencer and the I2C
//   byte engine (i2c_master).
//
//   Requester -> byte engine:
//     i2c_en           request another byte (0 at a byte-complete pulse => STOP)
//     i2c_addr         7-bit device address
//     i2c_write        1 = next byte is a write, 0 = a read
//     i2c_wdata        byte to write
//     i2c_multibyte_n  0 = chain bytes into one transaction
//   Byte engine -> requester:
//     i2c_next         byte-complete pulse; controls are sampled in this cycle
//     i2c_rdata        read byte, valid while i2c_next=1 on a read
//     i2c_act          a bus transaction is in progress
//     i2c_err          NACK / bus error pulse
//
//   modport master : the sequencer side (issues byte requests)
//   modport slave  : the byte-engine side (answers them)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface mpu_burst_reader_if;
    logic       i2c_en;
    logic [6:0] i2c_addr;
    logic       i2c_write;
    logic [7:0] i2c_wdata;
    logic       i2c_multibyte_n;
    logic       i2c_next;
    logic [7:0] i2c_rdata;
    logic       i2c_act;
    logic       i2c_err;

    modport master (
        output i2c_en, i2c_addr, i2c_write, i2c_wdata, i2c_multibyte_n,
        input  i2c_next, i2c_rdata, i2c_act, i2c_err
    );

    modport slave (
        input  i2c_en, i2c_addr, i2c_write, i2c_wdata, i2c_multibyte_n,
        output i2c_next, i2c_rdata, i2c_act, i2c_err
    );
endinterface

// File: rtl/mpu_burst_reader.sv
// ---------------------------------------------------------------------------
// mpu_burst_reader
//   Sequencer sitting in front of an I2C byte engine. Each accepted start
//   writes the register pointer START_REG to the MPU9250 and then reads 14
//   bytes in one chained transaction. The big-endian bytes become seven
//   signed 16-bit words that all update in the same cycle, flagged by a
//   one-cycle sample_valid. A NACK or a stalled byte engine aborts the
//   transfer with a one-cycle fault strobe and a sticky fault code.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             one-cycle fetch request (ignored while busy)
//   o_busy              high from accepted start until the bus is released
//   o_sample_valid      one-cycle strobe: all seven words updated
//   o_accel_x/y/z       words 0..2   (bytes 0..5)
//   o_temp              word 3       (bytes 6,7)
//   o_gyro_x/y/z        words 4..6   (bytes 8..13)
//   o_fault             one-cycle strobe on abort
//   o_fault_code        01 NACK, 10 timeout, 00 none since reset (sticky)
//   bus                 byte handshake to the I2C engine (master modport)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mpu_burst_reader #(
    parameter logic [6:0] DEV_ADDR  = 7'h68,
    parameter logic [7:0] START_REG = 8'h3B,
    parameter int         TIMEOUT   = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_sample_valid,
    output logic [15:0]        o_accel_x,
    output logic [15:0]        o_accel_y,
    output logic [15:0]        o_accel_z,
    output logic [15:0]        o_temp,
    output logic [15:0]        o_gyro_x,
    output logic [15:0]        o_gyro_y,
    output logic [15:0]        o_gyro_z,
    output logic               o_fault,
    output logic [1:0]         o_fault_code,
    mpu_burst_reader_if.master bus
);

    localparam int              WD_W        = $clog2(TIMEOUT + 1);
    // Abort is decided in the cycle where TIMEOUT cycles have gone by without
    // a byte-complete pulse; the counter reads TIMEOUT-1 in that cycle.
    localparam logic [WD_W-1:0] WD_LIMIT    = WD_W'(TIMEOUT - 1);
    localparam logic [3:0]      LAST_IDX    = 4'd13;
    localparam logic [3:0]      EN_DROP_IDX = 4'd12;
    localparam logic [1:0]      CODE_NACK   = 2'b01;
    localparam logic [1:0]      CODE_TMO    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PTR   = 3'd1,
        ST_READ  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_busy;
    logic            r_sample_valid;
    logic            r_fault;
    logic [1:0]      r_fault_code;
    logic [15:0]     r_words [0:6];
    logic [7:0]      r_shadow [0:12];
    logic [3:0]      r_byte_cnt;
    logic [WD_W-1:0] r_wd;

    logic            r_i2c_en;
    logic [6:0]      r_i2c_addr;
    logic            r_i2c_write;
    logic [7:0]      r_i2c_wdata;
    logic            r_i2c_multibyte_n;

    logic            w_accept;     // start taken in IDLE
    logic            w_ptr_ack;    // pointer byte completed
    logic            w_capture;    // read byte completed cleanly
    logic            w_last;       // the captured byte is byte 13
    logic            w_nack;       // abort on bus error
    logic            w_timeout;    // abort on watchdog
    logic            w_release;    // bus idle, return to IDLE
    logic            w_wd_expired;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle event flags; error beats a coincident
    // byte-complete pulse, and a byte-complete pulse beats the watchdog.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_ptr_ack    = 1'b0;
        w_capture    = 1'b0;
        w_last       = 1'b0;
        w_nack       = 1'b0;
        w_timeout    = 1'b0;
        w_release    = 1'b0;
        w_wd_expired = (r_wd == WD_LIMIT);
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_PTR;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PTR: begin
                if (bus.i2c_err) begin
                    w_state_nxt = ST_ABORT;
                    w_nack      = 1'b1;
                end else if (bus.i2c_next) begin
                    w_state_nxt = ST_READ;
                    w_ptr_ack   = 1'b1;
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_ABORT;
                    w_timeout   = 1'b1;
                end else begin
                    w_state_nxt = ST_PTR;
                end
            end
            ST_READ: begin
                if (bus.i2c_err) begin
                    w_state_nxt = ST_ABORT;
                    w_nack      = 1'b1;
                end else if (bus.i2c_next) begin
                    w_capture = 1'b1;
                    if (r_byte_cnt == LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                        w_last      = 1'b1;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end else if (w_wd_expired) begin
                    w_state_nxt = ST_ABORT;
                    w_timeout   = 1'b1;
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_DONE, ST_ABORT: begin
                if (!bus.i2c_act) begin
                    w_state_nxt = ST_IDLE;
                    w_release   = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Watchdog: cycles since the last byte-complete pulse (or since start)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd <= {WD_W{1'b0}};
        end else if (w_accept || bus.i2c_next) begin
            r_wd <= {WD_W{1'b0}};
        end else if ((r_state == ST_PTR) || (r_state == ST_READ)) begin
            r_wd <= r_wd + WD_W'(1);
        end else begin
            r_wd <= {WD_W{1'b0}};
        end
    end

    // Byte-engine controls; en drops at byte 12 so the engine stops after 13
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_i2c_en          <= 1'b0;
            r_i2c_addr        <= DEV_ADDR;
            r_i2c_write       <= 1'b1;
            r_i2c_wdata       <= 8'h00;
            r_i2c_multibyte_n <= 1'b0;
        end else begin
            r_i2c_addr        <= DEV_ADDR;
            r_i2c_multibyte_n <= 1'b0;
            if (w_accept) begin
                r_i2c_en    <= 1'b1;
                r_i2c_write <= 1'b1;
                r_i2c_wdata <= START_REG;
            end else if (w_ptr_ack) begin
                r_i2c_write <= 1'b0;
                r_i2c_wdata <= 8'h00;
            end else if (w_capture && (r_byte_cnt == EN_DROP_IDX)) begin
                r_i2c_en <= 1'b0;
            end else if (w_nack || w_timeout) begin
                r_i2c_en <= 1'b0;
            end else begin
                r_i2c_en <= r_i2c_en;
            end
        end
    end

    // Read-byte capture into the private shadow buffer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte_cnt <= 4'd0;
            for (int i = 0; i < 13; i++) begin
                r_shadow[i] <= 8'h00;
            end
        end else if (w_ptr_ack) begin
            r_byte_cnt <= 4'd0;
        end else if (w_capture) begin
            // Byte 13 goes straight to the outputs and is never buffered.
            if (r_byte_cnt != LAST_IDX) begin
                r_shadow[r_byte_cnt] <= bus.i2c_rdata;
            end
            if (w_last) begin
                r_byte_cnt <= 4'd0;
            end else begin
                r_byte_cnt <= r_byte_cnt + 4'd1;
            end
        end else begin
            r_byte_cnt <= r_byte_cnt;
        end
    end

    // Word outputs: one atomic update from the shadow plus the final byte
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 7; i++) begin
                r_words[i] <= 16'h0000;
            end
        end else if (w_last) begin
            for (int i = 0; i < 6; i++) begin
                r_words[i] <= {r_shadow[2 * i], r_shadow[2 * i + 1]};
            end
            r_words[6] <= {r_shadow[12], bus.i2c_rdata};
        end else begin
            for (int i = 0; i < 7; i++) begin
                r_words[i] <= r_words[i];
            end
        end
    end

    // Status: busy, strobes and sticky fault code
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy         <= 1'b0;
            r_sample_valid <= 1'b0;
            r_fault        <= 1'b0;
            r_fault_code   <= 2'b00;
        end else begin
            r_sample_valid <= w_last;
            r_fault        <= w_nack || w_timeout;
            if (w_nack) begin
                r_fault_code <= CODE_NACK;
            end else if (w_timeout) begin
                r_fault_code <= CODE_TMO;
            end else begin
                r_fault_code <= r_fault_code;
            end
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_release) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
        end
    end

    assign o_busy               = r_busy;
    assign o_sample_valid       = r_sample_valid;
    assign o_fault              = r_fault;
    assign o_fault_code         = r_fault_code;
    assign o_accel_x            = r_words[0];
    assign o_accel_y            = r_words[1];
    assign o_accel_z            = r_words[2];
    assign o_temp               = r_words[3];
    assign o_gyro_x             = r_words[4];
    assign o_gyro_y             = r_words[5];
    assign o_gyro_z             = r_words[6];
    assign bus.i2c_en           = r_i2c_en;
    assign bus.i2c_addr         = r_i2c_addr;
    assign bus.i2c_write        = r_i2c_write;
    assign bus.i2c_wdata        = r_i2c_wdata;
    assign bus.i2c_multibyte_n  = r_i2c_multibyte_n;

endmodule
